pid_terminos: RTL and testbench

Producer side of the PID term interface: takes one signed error sample per control period and computes the Proporcional, Integral and Derivada terms. It delivers them to the downstream final-sum stage with a one-cycle `IPDready` strobe. A single shared signed multiplier is time-multiplexed by a small FSM; the integral accumulator and previous-error register persist between samples.

---
 rtl/pid_pkg.sv | 39 +++
 rtl/pid_terminos_if.sv | 34 +++
 rtl/mult_sat.sv | 28 ++
 rtl/pid_terminos.sv | 161 ++++++++++++++++
 tb/tb_pid_terminos.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pid_pkg
//  Description : Shared types and helpers for the PID term producer:
//                FSM state encoding, full-scale saturation limits and sat().
//  Revision    : 1.0 - initial release
// ============================================================================
package pid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_P   = 3'd1,
        ST_MUL_I   = 3'd2,
        ST_MUL_D   = 3'd3,
        ST_PUBLISH = 3'd4
    } pid_state_t;

    // Largest positive value representable in a w-bit two's complement word
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most negative value representable in a w-bit two's complement word
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Clamp a wide signed value into the w-bit signed range
    function automatic longint sat(input longint x, input int w);
        if (x > sat_max(w)) begin
            return sat_max(w);
        end else if (x < sat_min(w)) begin
            return sat_min(w);
        end
        return x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_terminos_if.sv
`default_nettype none
// ============================================================================
//  Module      : pid_terminos_if
//  Description : Sample/gain inputs and term outputs of the PID term producer.
//                master = software/sample source side, slave = pid_terminos.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pid_terminos_if #(
    parameter int ancho = 19
);
    logic signed [ancho-1:0] Error;
    logic                    ErrorReady;
    logic signed [ancho-1:0] Kp;
    logic signed [ancho-1:0] Ki;
    logic signed [ancho-1:0] Kd;
    logic                    IntClear;
    logic signed [ancho-1:0] Integral;
    logic signed [ancho-1:0] Proporcional;
    logic signed [ancho-1:0] Derivada;
    logic                    IPDready;
    logic                    Ocupado;
    logic                    Perdido;

    modport master (
        output Error, ErrorReady, Kp, Ki, Kd, IntClear,
        input  Integral, Proporcional, Derivada, IPDready, Ocupado, Perdido
    );

    modport slave (
        input  Error, ErrorReady, Kp, Ki, Kd, IntClear,
        output Integral, Proporcional, Derivada, IPDready, Ocupado, Perdido
    );
endinterface
`default_nettype wire

// File: rtl/mult_sat.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sat
//  Description : Signed ancho x (ancho+1) multiplier, arithmetic right shift
//                by fracc (floor), saturated back to ancho bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_sat
    import pid_pkg::*;
#(
    parameter int ancho = 19,
    parameter int fracc = 8
) (
    input  wire logic signed [ancho-1:0] a,
    input  wire logic signed [ancho:0]   b,
    output logic signed [ancho-1:0]      y
);
    logic signed [2*ancho:0] prod;
    logic signed [2*ancho:0] shifted;

    // Full-precision product, floor shift, then clamp to the term width
    always_comb begin
        prod    = $signed({{(ancho + 1){a[ancho-1]}}, a}) * $signed({{ancho{b[ancho]}}, b});
        shifted = prod >>> fracc;
        y       = ancho'(sat(longint'(shifted), ancho));
    end
endmodule
`default_nettype wire

// File: rtl/pid_terminos.sv
`default_nettype none
// ============================================================================
//  Module      : pid_terminos
//  Description : PID term producer. One error sample per control period is
//                turned into Proporcional/Integral/Derivada terms using a
//                single time-multiplexed saturating multiplier; terms are
//                published together with a one-cycle IPDready strobe.
//                Optional macro PID_ANTIWINDUP_EN clamps the integral
//                accumulator to [-IntLim, IntLim].
//  Revision    : 1.0 - initial release
// ============================================================================
module pid_terminos
    import pid_pkg::*;
#(
    parameter int ancho  = 19,
    parameter int fracc  = 8,
    parameter int IntLim = 2**(ancho-1) - 1
) (
    input  wire logic     clk,
    input  wire logic     reset,
    pid_terminos_if.slave bus
);
    pid_state_t state;
    pid_state_t state_nxt;

    logic signed [ancho-1:0] e_r;
    logic signed [ancho:0]   diff_r;
    logic signed [ancho-1:0] e_prev;
    logic signed [ancho-1:0] acc;
    logic signed [ancho-1:0] p_r;
    logic signed [ancho-1:0] d_r;

    logic signed [ancho-1:0] mul_a;
    logic signed [ancho:0]   mul_b;
    logic signed [ancho-1:0] mul_y;

    logic signed [ancho-1:0] prev_eff;
    logic signed [ancho:0]   diff_in;
    logic signed [ancho:0]   acc_sum;
    logic signed [ancho-1:0] acc_sat;
    logic signed [ancho-1:0] acc_next;

    mult_sat #(
        .ancho (ancho),
        .fracc (fracc)
    ) u_mult (
        .a (mul_a),
        .b (mul_b),
        .y (mul_y)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fixed P -> I -> D -> publish sequence, IntClear aborts
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.ErrorReady) state_nxt = ST_MUL_P;
            ST_MUL_P:   state_nxt = ST_MUL_I;
            ST_MUL_I:   state_nxt = ST_MUL_D;
            ST_MUL_D:   state_nxt = ST_PUBLISH;
            ST_PUBLISH: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        // In IDLE a simultaneous sample is still accepted (with cleared history)
        if (bus.IntClear && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end
    end

    // Operand mux for the shared multiplier
    always_comb begin
        mul_a = bus.Kp;
        mul_b = {e_r[ancho-1], e_r};
        case (state)
            ST_MUL_I: mul_a = bus.Ki;
            ST_MUL_D: begin
                mul_a = bus.Kd;
                mul_b = diff_r;
            end
            default: ;
        endcase
    end

    // Difference at acceptance and saturating integral update
    always_comb begin
        prev_eff = bus.IntClear ? '0 : e_prev;
        diff_in  = $signed({bus.Error[ancho-1], bus.Error}) - $signed({prev_eff[ancho-1], prev_eff});
        acc_sum  = $signed({acc[ancho-1], acc}) + $signed({mul_y[ancho-1], mul_y});
        acc_sat  = ancho'(sat(longint'(acc_sum), ancho));
`ifdef PID_ANTIWINDUP_EN
        if (longint'(acc_sat) > longint'(IntLim)) begin
            acc_next = ancho'(longint'(IntLim));
        end else if (longint'(acc_sat) < -longint'(IntLim)) begin
            acc_next = ancho'(-longint'(IntLim));
        end else begin
            acc_next = acc_sat;
        end
`else
        acc_next = acc_sat;
`endif
    end

    // Busy from acceptance through the publish strobe cycle
    assign bus.Ocupado = (state != ST_IDLE) || bus.IPDready;

    // Datapath registers, sticky overrun flag and published terms
    always_ff @(posedge clk) begin
        if (reset) begin
            e_r              <= '0;
            diff_r           <= '0;
            e_prev           <= '0;
            acc              <= '0;
            p_r              <= '0;
            d_r              <= '0;
            bus.Integral     <= '0;
            bus.Proporcional <= '0;
            bus.Derivada     <= '0;
            bus.IPDready     <= 1'b0;
            bus.Perdido      <= 1'b0;
        end else begin
            bus.IPDready <= 1'b0;
            if (bus.ErrorReady && (state != ST_IDLE)) begin
                bus.Perdido <= 1'b1;
            end
            if (bus.IntClear) begin
                acc    <= '0;
                e_prev <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.ErrorReady) begin
                        e_r    <= bus.Error;
                        diff_r <= diff_in;
                    end
                end
                ST_MUL_P: if (!bus.IntClear) p_r <= mul_y;
                ST_MUL_I: if (!bus.IntClear) acc <= acc_next;
                ST_MUL_D: if (!bus.IntClear) d_r <= mul_y;
                ST_PUBLISH: begin
                    if (!bus.IntClear) begin
                        bus.Proporcional <= p_r;
                        bus.Integral     <= acc;
                        bus.Derivada     <= d_r;
                        bus.IPDready     <= 1'b1;
                        e_prev           <= e_r;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pid_terminos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pid_terminos
//  Description : Self-checking bench for pid_terminos: directed scenarios plus
//                randomized samples compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pid_terminos;
    localparam int W   = 19;
    localparam int F   = 8;
    localparam int LIM = 1000;
    localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W - 1));

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pid_terminos_if #(.ancho(W)) bus();

    pid_terminos #(
        .ancho  (W),
        .fracc  (F),
        .IntLim (LIM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint kp, ki, kd;
    longint m_acc, m_prev, m_p, m_i, m_d;
    bit     m_lost;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clampv(input longint x, input longint lo, input longint hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic longint term(input longint k, input longint v);
        return clampv((k * v) >>> F, MINV, MAXV);
    endfunction

    function automatic longint rnd(input int bits);
        return longint'($urandom_range(0, (1 << bits) - 1)) - (longint'(1) <<< (bits - 1));
    endfunction

    task automatic set_gains(input longint p, input longint i, input longint d);
        kp = p; ki = i; kd = d;
        bus.Kp = W'(p); bus.Ki = W'(i); bus.Kd = W'(d);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".P"}, bus.Proporcional, m_p);
        check({tag, ".I"}, bus.Integral, m_i);
        check({tag, ".D"}, bus.Derivada, m_d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; bus.ErrorReady = 1'b0; bus.IntClear = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        m_acc = 0; m_prev = 0; m_p = 0; m_i = 0; m_d = 0; m_lost = 0;
        check("rst.ready", bus.IPDready, 0);
        check("rst.busy", bus.Ocupado, 0);
        check("rst.lost", bus.Perdido, 0);
        check_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            check("idle.ready", bus.IPDready, 0);
            check("idle.busy", bus.Ocupado, 0);
            check_outputs("idle");
        end
    endtask

    // abort_kind: 0 none, 1 IntClear, 2 reset; edges counted after acceptance
    task automatic run_sample(input longint e, input int abort_edge, input int abort_kind,
                              input int over_edge, input bit clear_at_accept);
        longint np, ni, nd;
        @(negedge clk);
        bus.Error = W'(e); bus.ErrorReady = 1'b1; bus.IntClear = clear_at_accept;
        if (clear_at_accept) begin
            m_acc = 0; m_prev = 0;
        end
        np = term(kp, e);
        ni = clampv(m_acc + term(ki, e), MINV, MAXV);
`ifdef PID_ANTIWINDUP_EN
        ni = clampv(ni, -LIM, LIM);
`endif
        nd = term(kd, e - m_prev);
        @(posedge clk);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            bus.ErrorReady = (j == over_edge);
            bus.Error      = W'(rnd(W));
            bus.IntClear   = (abort_kind == 1) && (j == abort_edge);
            reset          = (abort_kind == 2) && (j == abort_edge);
            @(posedge clk); #1;
            if (j == over_edge) m_lost = 1;
            if ((abort_kind != 0) && (j == abort_edge)) begin
                m_acc = 0; m_prev = 0;
                if (abort_kind == 2) begin
                    m_p = 0; m_i = 0; m_d = 0; m_lost = 0;
                end
                check("abort.ready", bus.IPDready, 0);
                check("abort.busy", bus.Ocupado, 0);
                check("abort.lost", bus.Perdido, m_lost);
                check_outputs("abort");
                break;
            end
            if (j == 4) begin
                m_p = np; m_i = ni; m_d = nd; m_acc = ni; m_prev = e;
            end
            check("run.ready", bus.IPDready, (j == 4));
            check("run.busy", bus.Ocupado, 1);
            check("run.lost", bus.Perdido, m_lost);
            check_outputs("run");
        end
        @(negedge clk);
        bus.ErrorReady = 1'b0; bus.IntClear = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.Error = '0; bus.ErrorReady = 1'b0; bus.IntClear = 1'b0;
        set_gains(256, 128, 512);
        do_reset();

        // Basic: two samples of 100
        run_sample(100, 0, 0, 0, 0);
        check("basic1.P", bus.Proporcional, 100);
        check("basic1.I", bus.Integral, 50);
        check("basic1.D", bus.Derivada, 200);
        idle_cycles(1);
        run_sample(100, 0, 0, 0, 0);
        check("basic2.I", bus.Integral, 100);
        check("basic2.D", bus.Derivada, 0);
        idle_cycles(2);

        // Negative full-scale saturation
        do_reset();
        set_gains(262143, 128, 262143);
        run_sample(-262144, 0, 0, 0, 0);
        check("sat.P", bus.Proporcional, -262144);
        check("sat.D", bus.Derivada, -262144);
        idle_cycles(1);

        // Overrun two cycles after acceptance
        do_reset();
        set_gains(256, 128, 512);
        run_sample(100, 0, 0, 2, 0);
        check("over.lost", bus.Perdido, 1);
        check("over.P", bus.Proporcional, 100);
        idle_cycles(2);

        // IntClear during MUL_I with acc=500
        do_reset();
        run_sample(1000, 0, 0, 0, 0);
        check("clr.acc", bus.Integral, 500);
        run_sample(7, 2, 1, 0, 0);
        idle_cycles(3);
        run_sample(10, 0, 0, 0, 0);
        check("clr.I", bus.Integral, 5);
        check("clr.D", bus.Derivada, 20);

        // Integral limit behaviour (model follows the build option)
        do_reset();
        set_gains(256, 256, 512);
        run_sample(600, 0, 0, 0, 0);
        check("aw1.I", bus.Integral, 600);
        run_sample(600, 0, 0, 0, 0);
`ifdef PID_ANTIWINDUP_EN
        check("aw2.I", bus.Integral, 1000);
`else
        check("aw2.I", bus.Integral, 1200);
`endif

        // Reset during MUL_D, then a fresh sample
        set_gains(256, 128, 512);
        run_sample(40, 3, 2, 0, 0);
        idle_cycles(1);
        run_sample(100, 0, 0, 0, 0);
        check("rstmid.I", bus.Integral, 50);
        check("rstmid.D", bus.Derivada, 200);

        // IntClear coincident with acceptance in IDLE
        run_sample(30, 0, 0, 0, 1);
        check("clracc.D", bus.Derivada, 60);

        // Randomized samples
        for (int n = 0; n < 60; n++) begin
            int mode;
            mode = int'($urandom_range(0, 9));
            if (mode < 3) set_gains(rnd(W), rnd(W), rnd(W));
            else if (mode < 6) set_gains(rnd(12), rnd(12), rnd(12));
            run_sample((mode == 9) ? rnd(W) : rnd(12),
                       (mode == 7) ? int'($urandom_range(1, 4)) : 0,
                       (mode == 7) ? 1 : 0,
                       (mode == 8) ? int'($urandom_range(1, 4)) : 0,
                       (mode == 5));
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout got %0d expected %0d", 0, 1);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end
endmodule
`default_nettype wire
